// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Steps an N_LED-wide LED pattern once per prescaler period. Four patterns:
// rotate-left, rotate-right, bounce (one lit LED travelling between the ends)
// and blink-all. The step period is DIV_MAX >> speed clock cycles.
//
// Parameters
//   N_LED    LED count (2..32)
//   DIV_MAX  base step period in clk_50Mhz cycles (>= 8)
//   CNT_W    prescaler width, 2**CNT_W > DIV_MAX
//
// Ports
//   clk_50Mhz  in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   mode       in   00 rotate-left, 01 rotate-right, 10 bounce, 11 blink-all
//   speed      in   step period = DIV_MAX >> speed
//   pause      in   freeze prescaler and pattern while high
//   LED        out  registered pattern
//   tick       out  registered one-cycle pulse, coincident with each LED step
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module led_sequencer #(
    parameter int N_LED   = 4,
    parameter int DIV_MAX = 10000000,
    parameter int CNT_W   = 24
) (
    input  logic             clk_50Mhz,
    input  logic             RST,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             pause,
    output logic [N_LED-1:0] LED,
    output logic             tick
);

    localparam logic [N_LED-1:0] SEED_ONE = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] ALL_ONES = {N_LED{1'b1}};
    localparam logic [N_LED-1:0] ALL_ZERO = {N_LED{1'b0}};
    localparam logic [CNT_W-1:0] DIV_C    = CNT_W'(DIV_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [N_LED-1:0] v);
        return (v != ALL_ZERO) && ((v & (v - SEED_ONE)) == ALL_ZERO);
    endfunction

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [N_LED-1:0] led_q,  led_d;
    logic             dir_q,  dir_d;
    logic             tick_q, tick_d;
    logic [1:0]       mode_q, mode_d;

    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] last_s;
    logic [N_LED-1:0] shl_s;
    logic [N_LED-1:0] shr_s;

    // Period and single-position shifts used by the bounce pattern.
    always_comb begin
        period_s = DIV_C >> speed;
        last_s   = period_s - CNT_ONE;
        shl_s    = led_q << 1;
        shr_s    = led_q >> 1;
    end

    // Next-state: reseed on mode change, hold on pause, otherwise count/step.
    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        mode_d = mode;
        if (mode != mode_q) begin
            cnt_d = CNT_ZERO;
            dir_d = 1'b0;
            led_d = (mode == 2'b11) ? ALL_ZERO : SEED_ONE;
        end else if (pause) begin
            cnt_d = cnt_q;
        end else if (cnt_q >= last_s) begin
            // ">=" also catches a speed change that left cnt beyond the new
            // end of period. A step due in the cycle right after a step (only
            // possible at a 1-cycle period) waits one cycle so tick can never
            // be high twice in a row.
            if (!tick_q) begin
                cnt_d  = CNT_ZERO;
                tick_d = 1'b1;
                case (mode_q)
                    2'b00: begin
                        if (is_one_hot(led_q)) begin
                            led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
                        end else begin
                            led_d = SEED_ONE;
                        end
                    end
                    2'b01: begin
                        if (is_one_hot(led_q)) begin
                            led_d = {led_q[0], led_q[N_LED-1:1]};
                        end else begin
                            led_d = SEED_ONE;
                        end
                    end
                    2'b10: begin
                        if (!is_one_hot(led_q)) begin
                            led_d = SEED_ONE;
                            dir_d = 1'b0;
                        end else if (!dir_q) begin
                            led_d = shl_s;
                            dir_d = shl_s[N_LED-1];
                        end else begin
                            led_d = shr_s;
                            dir_d = !shr_s[0];
                        end
                    end
                    2'b11: begin
                        led_d = (led_q == ALL_ONES) ? ALL_ZERO : ALL_ONES;
                    end
                    default: begin
                        led_d = SEED_ONE;
                    end
                endcase
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_50Mhz or negedge RST) begin
        if (!RST) begin
            cnt_q  <= CNT_ZERO;
            led_q  <= SEED_ONE;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            mode_q <= mode_d;
        end
    end

    assign LED  = led_q;
    assign tick = tick_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameters (name, default, meaning), the block SHALL provide:
- N_LED, 4, LED count; legal range 2..32.
- DIV_MAX, 10000000, base step period in clk_50Mhz cycles; legal range >= 8.
- CNT_W, 24, prescaler width; SHALL satisfy 2^CNT_W > DIV_MAX.
REQ-002 Ports (name, direction, width, meaning), the block SHALL provide:
- clk_50Mhz, in, 1, system clock; all logic on rising edge.
- RST, in, 1, reset, asynchronous, active-low.
- mode, in, 2, pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 blink-all.
- speed, in, 2, step period = DIV_MAX >> speed.
- pause, in, 1, freeze prescaler and pattern while high.
- LED, out, N_LED, registered pattern output.
- tick, out, 1, registered one-cycle pulse coincident with each LED step.

Function
REQ-003 Prescaler cnt SHALL count 0..P-1 and wrap to 0, with P = DIV_MAX >> speed evaluated every cycle.
REQ-004 A step event SHALL occur on the cycle cnt == P-1 with pause low; tick SHALL be high exactly in the following cycle, together with the updated LED.
REQ-005 If speed changes so that cnt >= P-1, cnt SHALL generate a step event at the next non-paused cycle and wrap to 0 (no lost or runaway period).
REQ-006 While pause is high, cnt, LED, dir and tick SHALL hold (tick = 0); release SHALL resume counting from the held cnt.
REQ-007 Rotate-left step: LED <= {LED[N_LED-2:0], LED[N_LED-1]}.
REQ-008 Rotate-right step: LED <= {LED[0], LED[N_LED-1:1]}.
REQ-009 Bounce: a direction register dir (0 = toward MSB, 1 = toward LSB) SHALL govern the step: dir=0 shifts left one position, dir=1 shifts right one position.
REQ-010 Bounce reversal: a step that moves the bit into LED[N_LED-1] SHALL set dir=1; a step that moves it into LED[0] SHALL set dir=0; the endpoint is therefore lit for exactly one step period.
REQ-011 Blink-all step: LED <= ~LED restricted to all-ones/all-zeros; on entering mode 11 LED SHALL be loaded with all-zeros, so the first step lights all LEDs.
REQ-012 mode SHALL be registered (mode_q); when mode != mode_q, on that cycle cnt SHALL clear to 0, dir to 0, LED to its mode seed (one-hot 1 for modes 00/01/10, all-zeros for 11), tick = 0; this takes priority over a simultaneous step event and over pause.
REQ-013 If LED ever holds a value that is not one-hot in modes 00/01/10 (e.g. entered from blink), the next step SHALL reload one-hot 1 instead of shifting.
REQ-014 tick SHALL never be high for two consecutive cycles.

Reset
REQ-015 While RST is low: cnt = 0, LED = one-hot 1 (LED[0] only), dir = 0, tick = 0, mode_q = 00.
REQ-016 Deassertion of RST SHALL take effect at the next clk_50Mhz rising edge; if mode != 00 at that edge, REQ-012 reseed SHALL apply.
REQ-017 Assertion of RST mid-period or mid-bounce SHALL immediately force the REQ-015 values with no further step.

Verification (bench uses DIV_MAX=8, N_LED=4)
REQ-018 Reset release, mode=00, speed=0 -> LED = 0001, 0010, 0100, 1000, 0001 at 8-cycle intervals; tick pulses 1 cycle each step.
REQ-019 mode=10 from 0001 -> LED 0010, 0100, 1000, 0100, 0010, 0001, 0010; dir flips at 1000 and 0001.
REQ-020 speed 0->3 while cnt=6 -> step on next cycle, then period 1 cycle (8>>3); speed 3->1 -> period 4.
REQ-021 pause high for 20 cycles mid-period at cnt=3 -> LED, cnt frozen, tick 0; after release first step after 4 more cycles.
REQ-022 mode 00->11 on the same cycle as a step event -> LED = 0000, cnt = 0, no tick; after 8 cycles LED = 1111 with tick; mode 11->01 -> LED = 0001.
REQ-023 RST pulsed low for 1 ns mid-bounce with LED=0100, dir=1 -> LED = 0001, dir = 0, cnt = 0 asynchronously; tick 0.
